// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: time-shares one external digit adder, LSD first.
// Optional operand digit check is enabled with `define BCD_SEQ_DIGCHK_EN.
`timescale 1ns/1ps
module bcd_serial_add_ctrl #(
    parameter int unsigned NDIG = 4
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                start,
    input  logic [4*NDIG-1:0]   a_bcd,
    input  logic [4*NDIG-1:0]   b_bcd,
    input  logic                cin,
    output logic [3:0]          dig_x,
    output logic [3:0]          dig_y,
    output logic                dig_ci,
    input  logic [3:0]          dig_s,
    input  logic                dig_co,
    output logic [4*NDIG-1:0]   sum,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            done_q, done_d;
    logic [W-1:0]    work_shift;
    logic            last_step;
    logic            accept;

`ifdef BCD_SEQ_DIGCHK_EN
    logic err_q, err_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    // New digit enters at the MSD end so the LSD lands in [3:0] after NDIG shifts.
    always_comb begin
        work_shift              = work_q >> 4;
        work_shift[W-1 -: 4]    = dig_s;
    end

    assign last_step = (cnt_q == CntW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        accept  = 1'b0;
`ifdef BCD_SEQ_DIGCHK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                accept = start;
            end
            StRun: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                work_d  = work_shift;
                carry_d = dig_co;
                cnt_d   = cnt_q + CntW'(1);
                if (last_step) begin
                    sum_d   = work_shift;
                    cout_d  = dig_co;
                    done_d  = 1'b1;
                    state_d = StIdle;
`ifdef BCD_SEQ_DIGCHK_EN
                    err_d   = 1'b0;
`endif
                    // The completing edge doubles as the acceptance edge for back-to-back runs.
                    accept  = start;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
`ifdef BCD_SEQ_DIGCHK_EN
            if (bad_digit) begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = 1'b1;
                sum_d   = '0;
                cout_d  = 1'b0;
            end else begin
                state_d = StRun;
                a_d     = a_bcd;
                b_d     = b_bcd;
                carry_d = cin;
                cnt_d   = '0;
                work_d  = '0;
            end
`else
            state_d = StRun;
            a_d     = a_bcd;
            b_d     = b_bcd;
            carry_d = cin;
            cnt_d   = '0;
            work_d  = '0;
`endif
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_SEQ_DIGCHK_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy   = (state_q == StRun);
    assign dig_x  = busy ? a_q[3:0] : 4'd0;
    assign dig_y  = busy ? b_q[3:0] : 4'd0;
    assign dig_ci = busy ? carry_q : 1'b0;
    assign sum    = sum_q;
    assign cout   = cout_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: behavioural digit adder, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_bcd_serial_add_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_bcd = '0;
    logic [15:0] b_bcd = '0;
    logic        cin = 1'b0;
    logic [3:0]  dig_x, dig_y, dig_s;
    logic        dig_ci, dig_co;
    logic [15:0] sum;
    logic        cout, busy, done, err;

    int checks = 0;
    int passed = 0;

    bcd_serial_add_ctrl #(.NDIG(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .a_bcd  (a_bcd),
        .b_bcd  (b_bcd),
        .cin    (cin),
        .dig_x  (dig_x),
        .dig_y  (dig_y),
        .dig_ci (dig_ci),
        .dig_s  (dig_s),
        .dig_co (dig_co),
        .sum    (sum),
        .cout   (cout),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 Clock = ~Clock;

    // External single-digit BCD adder stage with >9 correction.
    logic [4:0] t;
    always_comb begin
        t      = {1'b0, dig_x} + {1'b0, dig_y} + {4'd0, dig_ci};
        dig_co = 1'b0;
        if (t > 5'd9) begin
            t      = t + 5'd6;
            dig_co = 1'b1;
        end
        dig_s = t[3:0];
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Starts one operation; returns cycles from acceptance edge to done (bounded).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          output int cyc);
        a_bcd = a; b_bcd = b; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [15:0] last_sum;

        vecs[0] = '{a: 16'h1234, b: 16'h5678, ci: 1'b0, s: 16'h6912, co: 1'b0};
        vecs[1] = '{a: 16'h9999, b: 16'h0001, ci: 1'b0, s: 16'h0000, co: 1'b1};
        vecs[2] = '{a: 16'h0000, b: 16'h0000, ci: 1'b1, s: 16'h0001, co: 1'b0};
        vecs[3] = '{a: 16'h9999, b: 16'h9999, ci: 1'b1, s: 16'h9999, co: 1'b1};
        vecs[4] = '{a: 16'h5000, b: 16'h5000, ci: 1'b0, s: 16'h0000, co: 1'b1};
        vecs[5] = '{a: 16'h0457, b: 16'h0389, ci: 1'b0, s: 16'h0846, co: 1'b0};

        // Reset state
        #12;
        check("reset_sum", 32'(sum), 32'h0);
        check("reset_flags", {28'd0, cout, busy, done, err}, 32'h0);
        check("reset_dig", {23'd0, dig_x, dig_y, dig_ci}, 32'h0);
        Resetn = 1'b1;
        tick();

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, cyc);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd4);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].co));
            check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), {30'd0, done, busy}, 32'h0);
        end
        last_sum = 16'h0846;

        // Ripple: 9999+0001, carry presented on steps 1..3, old sum held mid-run
        a_bcd = 16'h9999; b_bcd = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("ripple_busy", 32'(busy), 32'd1);
        check("ripple_ci0", 32'(dig_ci), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("ripple_ci%0d", k), 32'(dig_ci), 32'd1);
            check($sformatf("ripple_hold%0d", k), 32'(sum), 32'(last_sum));
        end
        tick();
        check("ripple_done", {15'd0, done, sum, cout}, {15'd0, 1'b1, 16'h0000, 1'b1});
        tick();

        // Back-to-back with start held through done
        a_bcd = 16'h0000; b_bcd = 16'h0000; cin = 1'b1; start = 1'b1;
        tick();
        a_bcd = 16'h0500; b_bcd = 16'h0500; cin = 1'b0;
        tick(); tick(); tick();
        check("b2b_nodone_early", 32'(done), 32'd0);
        tick();
        check("b2b_first", {14'd0, done, busy, sum}, {14'd0, 1'b1, 1'b1, 16'h0001});
        start = 1'b0;
        cyc = 0;
        tick();
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b2b_gap", 32'(cyc + 1), 32'd4);
        check("b2b_second", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h1000});
        tick();

        // Start during RUN ignored
        a_bcd = 16'h1111; b_bcd = 16'h2222; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a_bcd = 16'h9999;
        tick();
        start = 1'b0;
        check("ignore_hold", {15'd0, busy, sum}, {15'd0, 1'b1, 16'h1000});
        tick(); tick();
        check("ignore_sum", {15'd0, done, sum}, {15'd0, 1'b1, 16'h3333});
        tick();
        check("ignore_no_relaunch", {30'd0, done, busy}, 32'h0);

        // Invalid digit
        a_bcd = 16'h12A4; b_bcd = 16'h0000; cin = 1'b0;
`ifdef BCD_SEQ_DIGCHK_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_flags", {28'd0, done, err, busy, cout}, {28'd0, 4'b1100});
        check("err_sum", 32'(sum), 32'h0);
        tick();
        check("err_pulse", {30'd0, done, busy}, 32'h0);
`else
        run_op(16'h12A4, 16'h0000, 1'b0, cyc);
        check("bad_latency", 32'(cyc), 32'd4);
        check("bad_result", {14'd0, err, cout, sum}, {14'd0, 1'b0, 1'b0, 16'h1304});
        tick();
`endif

        // Asynchronous reset mid-run
        a_bcd = 16'h5555; b_bcd = 16'h5555; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 Resetn = 1'b0;
        #1;
        check("rst_async_out", {4'd0, sum, cout, busy, done, err, dig_x, dig_ci}, 32'h0);
        check("rst_async_y", 32'(dig_y), 32'h0);
        tick();
        tick();
        check("rst_no_done", {30'd0, done, busy}, 32'h0);
        Resetn = 1'b1;
        run_op(16'h0001, 16'h0002, 1'b0, cyc);
        check("post_rst_latency", 32'(cyc), 32'd4);
        check("post_rst_sum", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0003});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
